// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the full-speed USB receive front end.
package usb_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
      EOP,
      WAIT_J
   } rx_state_e;

   localparam int unsigned STUFF_LEN     = 6;
   localparam int unsigned BITS_PER_BYTE = 8;

   // Line-state encodings as {se0, j_not_k}
   localparam logic [1:0] LS_J   = 2'b01;
   localparam logic [1:0] LS_K   = 2'b00;
   localparam logic [1:0] LS_SE0 = 2'b10;

endpackage

// File: rtl/usb_rx_dpll.sv
// Line synchroniser and 4x-oversampling clock recovery; strobes once per bit at mid-bit.
module usb_rx_dpll
   import usb_rx_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       j_not_k,
   input  logic       se0,
   output logic [1:0] line,
   output logic       se0_now,
   output logic       strobe
);

   logic [1:0] meta;
   logic [1:0] sync;
   logic [1:0] phase;
   logic [1:0] phase_nxt;

   // line lags sync by one cycle so a bit cut short by an early edge is still sampled
   always_comb begin
      phase_nxt = phase + 2'd1;
      if (sync != line) begin
         phase_nxt = 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta   <= LS_J;
         sync   <= LS_J;
         line   <= LS_J;
         phase  <= 2'd0;
         strobe <= 1'b0;
      end else begin
         meta   <= {se0, j_not_k};
         sync   <= meta;
         line   <= sync;
         phase  <= phase_nxt;
         strobe <= (phase_nxt == 2'd2);
      end
   end

   assign se0_now = sync[1];

endmodule

// File: rtl/usb_rx_phy.sv
// Full-speed USB receiver: NRZI decode, SYNC detect, unstuffing, byte assembly, EOP and bus reset.
module usb_rx_phy
   import usb_rx_pkg::*;
#(
   parameter int unsigned RESET_CYCLES   = 120,
   parameter int unsigned SYNC_MIN_ZEROS = 3
) (
   input  logic       i_clk_48mhz,
   input  logic       i_rst,
   input  logic       i_usb_j_not_k,
   input  logic       i_usb_se0,
   input  logic       i_tx_active,
   output logic       o_rx_active,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   output logic       o_rx_eop,
   output logic       o_rx_err,
   output logic       o_usb_reset
);

   localparam int unsigned RST_CNT_W  = $clog2(RESET_CYCLES + 1);
   localparam int unsigned ZERO_CNT_W = $clog2(SYNC_MIN_ZEROS + 2);
   localparam int unsigned BIT_CNT_W  = $clog2(BITS_PER_BYTE);
   localparam int unsigned ONES_CNT_W = $clog2(STUFF_LEN + 1);

   logic [1:0]            line;
   logic                  se0_now;
   logic                  strobe;
   rx_state_e             state, state_nxt;
   logic                  prev_j, prev_j_nxt;
   logic [ZERO_CNT_W-1:0] zero_cnt, zero_cnt_nxt;
   logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
   logic [ONES_CNT_W-1:0] ones_cnt, ones_cnt_nxt;
   logic [6:0]            acc, acc_nxt;
   logic [7:0]            byte_c;
   logic                  active_nxt, valid_nxt, eop_nxt, err_nxt;
   logic [7:0]            data_nxt;
   logic                  is_j, is_k, is_se0, bit_val;
   logic [RST_CNT_W-1:0]  rst_cnt, rst_cnt_nxt;

   usb_rx_dpll u_dpll (
      .clk     (i_clk_48mhz),
      .rst     (i_rst),
      .j_not_k (i_usb_j_not_k),
      .se0     (i_usb_se0),
      .line    (line),
      .se0_now (se0_now),
      .strobe  (strobe)
   );

   assign is_j    = (line == LS_J);
   assign is_k    = (line == LS_K);
   assign is_se0  = line[1];
   assign bit_val = (line[0] == prev_j);
   assign byte_c  = {bit_val, acc};

   always_comb begin
      state_nxt    = state;
      prev_j_nxt   = prev_j;
      zero_cnt_nxt = zero_cnt;
      bit_cnt_nxt  = bit_cnt;
      ones_cnt_nxt = ones_cnt;
      acc_nxt      = acc;
      active_nxt   = o_rx_active;
      data_nxt     = o_rx_data;
      valid_nxt    = 1'b0;
      eop_nxt      = 1'b0;
      err_nxt      = 1'b0;
      if (i_tx_active) begin
         state_nxt    = IDLE;
         prev_j_nxt   = 1'b1;
         zero_cnt_nxt = '0;
         bit_cnt_nxt  = '0;
         ones_cnt_nxt = '0;
         active_nxt   = 1'b0;
      end else if (strobe) begin
         if (!is_se0) begin
            prev_j_nxt = line[0];
         end
         unique case (state)
            IDLE: begin
               if (is_k) begin
                  state_nxt    = SYNC;
                  zero_cnt_nxt = ZERO_CNT_W'(1);
               end
            end
            SYNC: begin
               if (is_se0) begin
                  state_nxt = WAIT_J;
               end else if (!bit_val) begin
                  if (zero_cnt != '1) begin
                     zero_cnt_nxt = zero_cnt + ZERO_CNT_W'(1);
                  end
               end else if (zero_cnt >= ZERO_CNT_W'(SYNC_MIN_ZEROS)) begin
                  state_nxt    = DATA;
                  active_nxt   = 1'b1;
                  bit_cnt_nxt  = '0;
                  ones_cnt_nxt = '0;
               end else begin
                  state_nxt = WAIT_J;
               end
            end
            DATA: begin
               if (is_se0) begin
                  state_nxt = EOP;
               end else if (ones_cnt == ONES_CNT_W'(STUFF_LEN)) begin
                  // stuff slot: a 0 is dropped, a 1 is a stuffing violation
                  if (bit_val) begin
                     err_nxt    = 1'b1;
                     active_nxt = 1'b0;
                     state_nxt  = WAIT_J;
                  end else begin
                     ones_cnt_nxt = '0;
                  end
               end else begin
                  ones_cnt_nxt = bit_val ? ones_cnt + ONES_CNT_W'(1) : '0;
                  acc_nxt      = byte_c[7:1];
                  if (bit_cnt == BIT_CNT_W'(BITS_PER_BYTE - 1)) begin
                     data_nxt    = byte_c;
                     valid_nxt   = 1'b1;
                     bit_cnt_nxt = '0;
                  end else begin
                     bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                  end
               end
            end
            EOP: begin
               if (is_j) begin
                  eop_nxt    = 1'b1;
                  err_nxt    = (bit_cnt > BIT_CNT_W'(1));
                  active_nxt = 1'b0;
                  state_nxt  = IDLE;
               end else if (is_k) begin
                  err_nxt    = 1'b1;
                  active_nxt = 1'b0;
                  state_nxt  = WAIT_J;
               end
            end
            WAIT_J: begin
               if (is_j) begin
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Bus-reset timer runs off the earliest synchronised SE0, independent of the FSM
   always_comb begin
      rst_cnt_nxt = '0;
      if (se0_now) begin
         rst_cnt_nxt = (rst_cnt == RST_CNT_W'(RESET_CYCLES)) ? rst_cnt : rst_cnt + RST_CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk_48mhz) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge i_clk_48mhz) begin
      if (i_rst) begin
         prev_j      <= 1'b1;
         zero_cnt    <= '0;
         bit_cnt     <= '0;
         ones_cnt    <= '0;
         acc         <= '0;
         o_rx_active <= 1'b0;
         o_rx_data   <= 8'h00;
         o_rx_valid  <= 1'b0;
         o_rx_eop    <= 1'b0;
         o_rx_err    <= 1'b0;
         rst_cnt     <= '0;
         o_usb_reset <= 1'b0;
      end else begin
         prev_j      <= prev_j_nxt;
         zero_cnt    <= zero_cnt_nxt;
         bit_cnt     <= bit_cnt_nxt;
         ones_cnt    <= ones_cnt_nxt;
         acc         <= acc_nxt;
         o_rx_active <= active_nxt;
         o_rx_data   <= data_nxt;
         o_rx_valid  <= valid_nxt;
         o_rx_eop    <= eop_nxt;
         o_rx_err    <= err_nxt;
         rst_cnt     <= rst_cnt_nxt;
         o_usb_reset <= (rst_cnt_nxt == RST_CNT_W'(RESET_CYCLES));
      end
   end

endmodule
